seq_div32: RTL and testbench
============================

Name: seq_div32

Overview:
- Multi-cycle 32-bit restoring divider; the inverse counterpart of the ALU's 32-bit carry adder.
- Executes MIPS DIV/DIVU and produces the quotient (LO) and remainder (HI).
- Sits beside the EX stage; the pipeline stalls while busy=1.
- Each iteration is one 32-bit subtract (A + ~B + 1) with borrow taken from the carry-out.

Parameters:
- WIDTH, 32: operand/result width; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1=DIV (two's complement), 0=DIVU
- dividend  input  WIDTH  numerator, latched on the accepted start
- divisor  input  WIDTH  denominator, latched on the accepted start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  to LO
- remainder  output  WIDTH  to HI
- div_zero  output  1  divisor was 0 for the last operation

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE.
  - busy, done, div_zero, quotient, remainder all =0.
  - The iteration counter is cleared and the in-flight operation is discarded.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge k:
  - Latch the magnitudes of the operands: the absolute value if is_signed and MSB=1, else raw.
  - Latch the sign flags: q_neg = sa^sb, r_neg = sa. Both are 0 when unsigned.
  - Clear the partial remainder; counter=0; busy=1.
  - If divisor==0: go to DONE at edge k+1.
  - Otherwise: go to CALC.
- CALC, one step per cycle:
  - Shift {rem, quo} left by one; form diff = rem_shifted - divisor_mag.
  - If there is no borrow: rem=diff, quotient LSB=1. Otherwise keep rem_shifted, quotient LSB=0.
  - After step WIDTH (edge k+WIDTH), load the output registers with sign-corrected results:
    - quotient = q_neg ? -quo : quo
    - remainder = r_neg ? -rem : rem
  - Then state=DONE, done=1, busy=0.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE with done=0.
  - A start seen in the DONE cycle is ignored.
- Latency: done is high during the cycle after edge k+WIDTH, i.e. 32 cycles after the accepting edge.
- Divide by zero:
  - quotient = all ones, remainder = original dividend (unsigned raw value), div_zero=1.
  - done is asserted after edge k+1.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - quotient=0x80000000, remainder=0, div_zero=0.
  - This falls out naturally from magnitude arithmetic with modulo-2^WIDTH wrap.
- Back-to-back: a start while busy=1 is ignored, and operands are not re-latched.
- Outputs hold their last result until the next accepted operation completes.
- div_zero holds until the next accepted start, where it is cleared.
- All arithmetic is modulo 2^WIDTH; the remainder sign always follows the dividend sign.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - WIDTH default.
  - Counter width: clog2(WIDTH)+1.
- One sub-module, sub_step32:
  - Combinational WIDTH-bit subtractor built as A + ~B with C0=1.
  - Outputs diff and no_borrow (= carry-out).
  - Reuses the adder style already in the ALU.

Test Plan:
- Unsigned: DIVU 100/7, start at edge k -> busy 1 from k, done pulse one cycle after edge k+32, quotient=14, remainder=2.
- Signed: DIV 0xFFFFFF9C (-100) / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 7 / -2 -> quotient=0xFFFFFFFD, remainder=1.
- Edge values:
  - DIVU 0x7FFFFFFF/3 -> quotient=0x2AAAAAAA, remainder=1.
  - DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero: 123/0 -> done after edge k+1, quotient=0xFFFFFFFF, remainder=123, div_zero=1.
  - The next valid op, 10/5, returns quotient=2 and clears div_zero.
- Handshake: pulse start with new operands at edges k+5 and k+32 during 100/7 -> ignored, result still 14/2.
  - The second op starts only from IDLE, after done.
- Reset mid-op: assert rst at k+10 (asynchronously, mid-cycle) -> busy, done, quotient, remainder drop to 0 immediately.
  - After release, 50/6 completes in full latency -> quotient=8, remainder=2.

Source files
------------

// File: rtl/seq_div32_pkg.sv
// Shared types and constants for the sequential 32-bit restoring divider.
package seq_div32_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must hold 0..WIDTH-1 with headroom, hence clog2+1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/seq_div32_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface seq_div32_if #(
   parameter int unsigned WIDTH = seq_div32_pkg::DIV_WIDTH
);

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );

endinterface

// File: rtl/seq_div32_sub_step32.sv
// Combinational subtractor A + ~B + 1; carry-out high means no borrow.
module sub_step32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_no_borrow
);

   logic [WIDTH:0] w_sum;

   assign w_sum       = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
   assign o_diff      = w_sum[WIDTH-1:0];
   assign o_no_borrow = w_sum[WIDTH];

endmodule

// File: rtl/seq_div32.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per cycle.
module seq_div32
   import seq_div32_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   seq_div32_if.slave  bus
);

   localparam int unsigned CntW = cnt_width(WIDTH);

   state_e           r_state;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dsr;
   logic             r_q_neg;
   logic             r_r_neg;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;

   logic             w_dvd_neg;
   logic             w_dsr_neg;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dsr_mag;
   logic [WIDTH-1:0] w_rem_sh;
   logic [WIDTH-1:0] w_diff;
   logic             w_no_borrow;
   logic             w_take;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic             w_last;

   assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
   assign w_dsr_neg = bus.is_signed & bus.divisor[WIDTH-1];
   assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
   assign w_dsr_mag = w_dsr_neg ? -bus.divisor : bus.divisor;

   assign w_rem_sh = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};

   sub_step32 #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_a         (w_rem_sh),
      .i_b         (r_dsr),
      .o_diff      (w_diff),
      .o_no_borrow (w_no_borrow)
   );

   // A bit shifted out of the remainder means the true value exceeds any divisor.
   assign w_take    = r_rem[WIDTH-1] | w_no_borrow;
   assign w_rem_nxt = w_take ? w_diff : w_rem_sh;
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_take};
   assign w_last    = (r_cnt == CntW'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dsr       <= '0;
         r_q_neg     <= 1'b0;
         r_r_neg     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div_zero  <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_quo      <= w_dvd_mag;
                  r_dsr      <= w_dsr_mag;
                  r_q_neg    <= w_dvd_neg ^ w_dsr_neg;
                  r_r_neg    <= w_dvd_neg;
                  r_rem      <= '0;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_div_zero <= (bus.divisor == '0);
                  r_state    <= CALC;
               end
            end
            CALC: begin
               if (r_div_zero) begin
                  // r_quo still holds the dividend magnitude; undo it to the raw value.
                  r_quotient  <= '1;
                  r_remainder <= r_r_neg ? -r_quo : r_quo;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + CntW'(1);
                  if (w_last) begin
                     r_quotient  <= r_q_neg ? -w_quo_nxt : w_quo_nxt;
                     r_remainder <= r_r_neg ? -w_rem_nxt : w_rem_nxt;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
   assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed cases plus random ops vs an arithmetic model.
module tb_seq_div32;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   seq_div32_if #(.WIDTH(32)) bus ();

   seq_div32 #(
      .WIDTH (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: native longint division (truncating, remainder follows dividend).
   function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
         dz = 1'b0;
      end else begin
         q  = a / b;
         r  = a % b;
         dz = 1'b0;
      end
   endfunction

   task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
      logic [31:0] eq;
      logic [31:0] er;
      logic        edz;
      int          n;
      model(sgn, a, b, eq, er, edz);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.dividend  = a;
      bus.divisor   = b;
      @(negedge clk);
      n            = 1;
      bus.start    = 1'b0;
      bus.dividend = ~a;
      bus.divisor  = b + 32'd1;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
         if (inject && (n == 5 || n == 32 || n == 33)) begin
            bus.start     = 1'b1;
            bus.is_signed = ~sgn;
            bus.dividend  = 32'd999;
            bus.divisor   = 32'd0;
         end else begin
            bus.start = 1'b0;
         end
      end
      check({tag, "_done"}, 32'(bus.done), 32'd1);
      check({tag, "_lat"}, 32'(n - 1), (b == 32'd0) ? 32'd1 : 32'd32);
      check({tag, "_q"}, bus.quotient, eq);
      check({tag, "_r"}, bus.remainder, er);
      check({tag, "_dz"}, 32'(bus.div_zero), 32'(edz));
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check({tag, "_hold_q"}, bus.quotient, eq);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          mode;
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      #12;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_q", bus.quotient, 32'd0);
      check("rst_r", bus.remainder, 32'd0);
      check("rst_dz", 32'(bus.div_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
      run_op("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
      run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      run_op("divu_max_3", 1'b0, 32'h7FFF_FFFF, 32'd3, 1'b0);
      run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_ff_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op("divu_big_dsr", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
      run_op("divu_123_0", 1'b0, 32'd123, 32'd0, 1'b0);
      run_op("divu_10_5", 1'b0, 32'd10, 32'd5, 1'b0);
      run_op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
      run_op("hs_100_7", 1'b0, 32'd100, 32'd7, 1'b1);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd100;
      bus.divisor   = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_q", bus.quotient, 32'd0);
      check("arst_r", bus.remainder, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("after_rst_50_6", 1'b0, 32'd50, 32'd6, 1'b0);

      for (int i = 0; i < 20; i++) begin
         ra   = $urandom;
         mode = int'($urandom_range(0, 7));
         if (mode == 0) rb = 32'd0;
         else if (mode <= 2) rb = 32'($urandom_range(1, 15));
         else if (mode == 3) rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         else rb = $urandom;
         run_op($sformatf("rnd%0d", i), bit'($urandom_range(0, 1)), ra, rb, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
